t01_speed_ramp_ctrl: RTL and testbench

T01_SPEED_RAMP_CTRL -- requirements
Module: t01_speed_ramp_ctrl

---
 rtl/t01_speed_ramp_ctrl.sv | 150 +++++++++++++++
 tb/tb_t01_speed_ramp_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/t01_speed_ramp_ctrl.sv
// t01_speed_ramp_ctrl
// Speed ramp for a falling-block game. The current score sets a speed level.
// The level sets the drop period, and a free-running counter emits drop_tick
// once per period while the game is running. Pause freezes the counter, and
// the clear gamestate returns everything to level 0.
// Optional feature: define T01_SPEED_SOFT_DROP_EN to let soft_drop select
// SOFT_PERIOD while running. When it is undefined, soft_drop is ignored.
module t01_speed_ramp_ctrl #(
  parameter int         SCORE_W     = 10,
  parameter int         LEVEL_W     = 5,
  parameter int         PERIOD_W    = 25,
  parameter int         STEP        = 10,
  parameter int         MAX_LEVEL   = 15,
  parameter int         BASE_PERIOD = 12_500_000,
  parameter int         PERIOD_DEC  = 1_000_000,
  parameter int         MIN_PERIOD  = 1_000_000,
  parameter int         SOFT_PERIOD = 500_000,
  parameter logic [3:0] CLEAR_STATE = 4'd9
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [SCORE_W-1:0]  current_score,
  input  logic [3:0]          gamestate,
  input  logic                pause,
  input  logic                soft_drop,
  output logic                drop_tick,
  output logic [LEVEL_W-1:0]  level,
  output logic [PERIOD_W-1:0] period,
  output logic                level_up
);

  localparam int WIDE_W = PERIOD_W + LEVEL_W;

`ifdef T01_SPEED_SOFT_DROP_EN
  localparam bit SOFT_EN = 1'b1;
`else
  localparam bit SOFT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                state_p1;
  state_t                state_nxt;
  logic [PERIOD_W-1:0]   cnt_p1;
  logic [PERIOD_W-1:0]   cnt_nxt;
  logic [LEVEL_W-1:0]    level_nxt;
  logic [LEVEL_W-1:0]    target_lvl;
  logic [PERIOD_W-1:0]   period_nxt;
  logic                  tick_nxt;
  logic                  level_up_nxt;
  logic                  clear;
  logic                  run_cnt;

  // The target level is score / STEP, saturated at MAX_LEVEL.
  function automatic logic [LEVEL_W-1:0] sat_level(input logic [SCORE_W-1:0] score);
    logic [SCORE_W-1:0] quo;
    quo = score / SCORE_W'(STEP);
    if (32'(quo) >= 32'(MAX_LEVEL))
      return LEVEL_W'(MAX_LEVEL);
    return LEVEL_W'(quo);
  endfunction

  // The base period drops with each level and is floored at MIN_PERIOD.
  // The subtraction is done wide so that it never wraps below zero.
  function automatic logic [PERIOD_W-1:0] floor_period(input logic [LEVEL_W-1:0] lvl);
    logic [WIDE_W-1:0] dec;
    logic [WIDE_W-1:0] diff;
    dec = WIDE_W'(lvl) * WIDE_W'(PERIOD_DEC);
    if (dec >= WIDE_W'(BASE_PERIOD))
      return PERIOD_W'(MIN_PERIOD);
    diff = WIDE_W'(BASE_PERIOD) - dec;
    if (diff < WIDE_W'(MIN_PERIOD))
      return PERIOD_W'(MIN_PERIOD);
    return PERIOD_W'(diff);
  endfunction

  assign clear      = (gamestate == CLEAR_STATE);
  assign target_lvl = sat_level(current_score);

  // Stage p0: next state, level, active period and counter.
  // The counter advances only when this cycle and the next are both RUN.
  // This keeps pause entry, pause exit and clear from emitting a tick.
  always_comb begin
    state_nxt    = state_p1;
    level_nxt    = level;
    period_nxt   = period;
    cnt_nxt      = cnt_p1;
    tick_nxt     = 1'b0;
    level_up_nxt = 1'b0;
    run_cnt      = 1'b0;

    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state_p1)
        IDLE:    state_nxt = RUN;
        RUN:     if (pause)  state_nxt = HOLD;
        HOLD:    if (!pause) state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end

    if (clear)
      level_nxt = '0;
    else if (target_lvl > level)
      level_nxt = target_lvl;
    level_up_nxt = (level_nxt > level);

    if (SOFT_EN && soft_drop && (state_nxt == RUN))
      period_nxt = PERIOD_W'(SOFT_PERIOD);
    else
      period_nxt = floor_period(level_nxt);

    run_cnt = (state_p1 == RUN) && (state_nxt == RUN);
    if (clear || (state_p1 == IDLE)) begin
      cnt_nxt = '0;
    end else if (run_cnt) begin
      if (cnt_p1 >= period - PERIOD_W'(1)) begin
        cnt_nxt  = '0;
        tick_nxt = 1'b1;
      end else begin
        cnt_nxt = cnt_p1 + PERIOD_W'(1);
      end
    end
  end

  // Stage p1: every output is registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_p1  <= IDLE;
      cnt_p1    <= '0;
      level     <= '0;
      period    <= PERIOD_W'(BASE_PERIOD);
      drop_tick <= 1'b0;
      level_up  <= 1'b0;
    end else begin
      state_p1  <= state_nxt;
      cnt_p1    <= cnt_nxt;
      level     <= level_nxt;
      period    <= period_nxt;
      drop_tick <= tick_nxt;
      level_up  <= level_up_nxt;
    end
  end

endmodule

// File: tb/tb_t01_speed_ramp_ctrl.sv
// Directed testbench for t01_speed_ramp_ctrl.
// Uses small parameters: BASE=20, DEC=4, MIN=6, STEP=10, MAX_LEVEL=7, SOFT=3.
module tb_t01_speed_ramp_ctrl;

  localparam int SCORE_W  = 10;
  localparam int LEVEL_W  = 5;
  localparam int PERIOD_W = 25;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [SCORE_W-1:0]  current_score;
  logic [3:0]          gamestate;
  logic                pause;
  logic                soft_drop;
  logic                drop_tick;
  logic [LEVEL_W-1:0]  level;
  logic [PERIOD_W-1:0] period;
  logic                level_up;

  int checks   = 0;
  int errors   = 0;
  int tick_cnt = 0;
  int lu_cnt   = 0;
  int tk;

  t01_speed_ramp_ctrl #(
    .SCORE_W(SCORE_W), .LEVEL_W(LEVEL_W), .PERIOD_W(PERIOD_W),
    .STEP(10), .MAX_LEVEL(7), .BASE_PERIOD(20), .PERIOD_DEC(4),
    .MIN_PERIOD(6), .SOFT_PERIOD(3), .CLEAR_STATE(4'd9)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .current_score(current_score),
    .gamestate(gamestate),
    .pause(pause),
    .soft_drop(soft_drop),
    .drop_tick(drop_tick),
    .level(level),
    .period(period),
    .level_up(level_up)
  );

  always #5 clk = ~clk;

  // Counts output pulses on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (drop_tick) tick_cnt = tick_cnt + 1;
    if (level_up)  lu_cnt   = lu_cnt + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advances until drop_tick is seen and checks the number of edges taken.
  // A negative expn only requires that some tick arrives within the bound.
  task automatic wait_tick(input string tag, input int expn);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      step(1);
      n++;
      if (drop_tick) seen = 1'b1;
    end
    if (expn < 0)
      chk(tag, 32'(seen), 32'd1);
    else
      chk(tag, seen ? 32'(n) : 32'hFFFF_FFFF, 32'(expn));
  endtask

  initial begin
    reset_n       = 1'b0;
    current_score = '0;
    gamestate     = 4'd0;
    pause         = 1'b0;
    soft_drop     = 1'b0;
    step(2);
    chk("rst_tick",   32'(drop_tick), 32'd0);
    chk("rst_level",  32'(level),     32'd0);
    chk("rst_period", 32'(period),    32'd20);
    chk("rst_lvlup",  32'(level_up),  32'd0);

    // Basic run: the first tick comes 20 cycles after RUN entry, then every 20.
    reset_n = 1'b1;
    step(1);
    wait_tick("first_tick", 20);
    step(1);
    chk("tick_one_cycle", 32'(drop_tick), 32'd0);
    wait_tick("tick_spacing20", 19);
    chk("period_l0", 32'(period), 32'd20);

    // Score 25 moves to level 2 with one pulse and period 12. Lowering the score keeps level 2.
    lu_cnt = 0;
    current_score = 10'd25;
    step(1);
    chk("lvl2", 32'(level), 32'd2);
    chk("lvl2_up", 32'(level_up), 32'd1);
    chk("period_l2", 32'(period), 32'd12);
    step(1);
    chk("lvl2_up_clr", 32'(level_up), 32'd0);
    current_score = 10'd5;
    step(2);
    chk("lvl_no_decrease", 32'(level), 32'd2);
    chk("lvlup_single", 32'(lu_cnt), 32'd1);
    wait_tick("sync_l2", -1);
    wait_tick("tick_spacing12", 12);

    // Score 99 saturates at level 7, and the period floors at 6.
    current_score = 10'd99;
    step(1);
    chk("lvl_sat", 32'(level), 32'd7);
    chk("period_floor", 32'(period), 32'd6);
    wait_tick("sync_l7", -1);
    wait_tick("tick_spacing6", 6);

    // Pause with the count at 2. After resume: 1 edge leaves HOLD, then 4 edges to the tick.
    step(2);
    pause = 1'b1;
    tk = tick_cnt;
    step(50);
    chk("pause_no_ticks", 32'(tick_cnt - tk), 32'd0);
    chk("pause_tick_low", 32'(drop_tick), 32'd0);
    pause = 1'b0;
    wait_tick("resume_count_kept", 5);

    // Clear returns to level 0 and period 20.
    gamestate = 4'd9;
    step(1);
    chk("clr_level", 32'(level), 32'd0);
    chk("clr_period", 32'(period), 32'd20);
    gamestate = 4'd0;
    current_score = 10'd55;
    step(1);
    chk("lvl5", 32'(level), 32'd5);
    chk("period_l5", 32'(period), 32'd6);
    step(3);
    gamestate = 4'd9;
    step(1);
    chk("clr_mid_level", 32'(level), 32'd0);
    chk("clr_mid_period", 32'(period), 32'd20);
    chk("clr_mid_tick", 32'(drop_tick), 32'd0);
    chk("clr_mid_lvlup", 32'(level_up), 32'd0);
    tk = tick_cnt;
    step(10);
    chk("clr_hold_no_ticks", 32'(tick_cnt - tk), 32'd0);
    chk("clr_hold_level", 32'(level), 32'd0);
    gamestate = 4'd0;
    current_score = 10'd0;
    wait_tick("clr_first_tick", 21);

    // An asynchronous reset mid-count discards the partial count.
    current_score = 10'd55;
    step(5);
    chk("pre_rst_level", 32'(level), 32'd5);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_period", 32'(period), 32'd20);
    chk("arst_tick", 32'(drop_tick), 32'd0);
    current_score = 10'd0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    wait_tick("rst_first_tick", 21);

    // Soft drop.
    soft_drop = 1'b1;
    step(1);
`ifdef T01_SPEED_SOFT_DROP_EN
    chk("soft_period", 32'(period), 32'd3);
    wait_tick("sync_soft", -1);
    wait_tick("soft_spacing", 3);
`else
    chk("soft_period", 32'(period), 32'd20);
    wait_tick("sync_soft", -1);
    wait_tick("soft_spacing", 20);
`endif
    soft_drop = 1'b0;
    step(1);
    chk("soft_off_period", 32'(period), 32'd20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
